// File: rtl/lc3b_types.sv
// Shared LC-3b type definitions: decoded control word, PC and performance-counter types.
package lc3b_types;

    typedef logic [15:0] lc3b_pc;
    typedef logic [31:0] lc3b_perf_cnt;

    typedef struct packed {
        logic [3:0] opcode;
        logic [2:0] aluop;
        logic [1:0] pcmux_sel;
        logic [1:0] regfilemux_sel;
        logic       load_regfile;
        logic       load_cc;
        logic       mem_read;
        logic       mem_write;
        logic       mem_byte;
    } lc3b_control_word;

    localparam int LC3B_CW_BITS = $bits(lc3b_control_word);
    localparam lc3b_control_word LC3B_NOP_CW = '0;

endpackage

// File: rtl/lc3b_ctrl_stage.sv
// One control-word pipeline stage register: flush beats hold, hold beats bubble,
// bubble beats load. Invalid contents are always forced to zero.
module lc3b_ctrl_stage #(
    parameter int CW_WIDTH = 16,
    parameter int PC_WIDTH = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush_i,
    input  logic                hold_i,
    input  logic                bubble_i,
    input  logic                valid_i,
    input  logic [CW_WIDTH-1:0] cw_i,
    input  logic [PC_WIDTH-1:0] pc_i,
    output logic                valid_o,
    output logic [CW_WIDTH-1:0] cw_o,
    output logic [PC_WIDTH-1:0] pc_o
);

    logic                valid_q, valid_d;
    logic [CW_WIDTH-1:0] cw_q, cw_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;

    always_comb begin
        valid_d = valid_q;
        cw_d    = cw_q;
        pc_d    = pc_q;
        if (flush_i || (!hold_i && bubble_i)) begin
            valid_d = 1'b0;
            cw_d    = '0;
            pc_d    = '0;
        end else if (!hold_i) begin
            // An invalid upstream slot still lands as an all-zero bubble.
            valid_d = valid_i;
            cw_d    = valid_i ? cw_i : '0;
            pc_d    = valid_i ? pc_i : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            cw_q    <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            cw_q    <= cw_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign cw_o    = cw_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/lc3b_ctrl_pipe.sv
// Rigid N-stage control-word pipeline with stall back-propagation, flush-younger,
// bubble insertion and retire/bubble performance counters.
module lc3b_ctrl_pipe
    import lc3b_types::*;
#(
    parameter int STAGES    = 4,
    parameter int CW_WIDTH  = LC3B_CW_BITS,
    parameter int PC_WIDTH  = 16,
    parameter int CNT_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [CW_WIDTH-1:0]          in_cw,
    input  logic [PC_WIDTH-1:0]          in_pc,
    output logic                         in_ready,
    input  logic [STAGES-1:0]            stall,
    input  logic [STAGES-1:0]            flush,
    output logic [STAGES-1:0]            stage_valid,
    output logic [STAGES*CW_WIDTH-1:0]   stage_cw,
    output logic [STAGES*PC_WIDTH-1:0]   stage_pc,
    output logic                         retire,
    output logic [CNT_WIDTH-1:0]         retire_count,
    output logic [CNT_WIDTH-1:0]         bubble_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [STAGES-1:0]   hold;
    logic [STAGES-1:0]   flush_any;
    logic [CW_WIDTH-1:0] cw_arr [STAGES];
    logic [PC_WIDTH-1:0] pc_arr [STAGES];
    logic                bubble_out;
    logic [CNT_WIDTH-1:0] retire_cnt_q, retire_cnt_d;
    logic [CNT_WIDTH-1:0] bubble_cnt_q, bubble_cnt_d;

    // A stall freezes its stage and everything younger; a flush kills its stage and everything younger.
    always_comb begin
        hold      = stall;
        flush_any = flush;
        for (int i = STAGES - 2; i >= 0; i--) begin
            hold[i]      = stall[i] | hold[i+1];
            flush_any[i] = flush[i] | flush_any[i+1];
        end
    end

    assign in_ready = !hold[0];

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        if (i == 0) begin : g_head
            lc3b_ctrl_stage #(.CW_WIDTH(CW_WIDTH), .PC_WIDTH(PC_WIDTH)) u_stage (
                .clk      (clk),
                .reset    (reset),
                .flush_i  (flush_any[i]),
                .hold_i   (hold[i]),
                .bubble_i (1'b0),
                .valid_i  (in_valid),
                .cw_i     (in_cw),
                .pc_i     (in_pc),
                .valid_o  (stage_valid[i]),
                .cw_o     (cw_arr[i]),
                .pc_o     (pc_arr[i])
            );
        end else begin : g_body
            lc3b_ctrl_stage #(.CW_WIDTH(CW_WIDTH), .PC_WIDTH(PC_WIDTH)) u_stage (
                .clk      (clk),
                .reset    (reset),
                .flush_i  (flush_any[i]),
                .hold_i   (hold[i]),
                .bubble_i (hold[i-1]),
                .valid_i  (stage_valid[i-1]),
                .cw_i     (cw_arr[i-1]),
                .pc_i     (pc_arr[i-1]),
                .valid_o  (stage_valid[i]),
                .cw_o     (cw_arr[i]),
                .pc_o     (pc_arr[i])
            );
        end
        assign stage_cw[i*CW_WIDTH +: CW_WIDTH] = cw_arr[i];
        assign stage_pc[i*PC_WIDTH +: PC_WIDTH] = pc_arr[i];
    end

    assign retire     =  stage_valid[STAGES-1] & !hold[STAGES-1] & !flush[STAGES-1];
    assign bubble_out = !stage_valid[STAGES-1] & !hold[STAGES-1] & !flush[STAGES-1];

    always_comb begin
        retire_cnt_d = retire_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (retire)     retire_cnt_d = retire_cnt_q + CNT_ONE;
        if (bubble_out) bubble_cnt_d = bubble_cnt_q + CNT_ONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retire_cnt_q <= '0;
            bubble_cnt_q <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign retire_count = retire_cnt_q;
    assign bubble_count = bubble_cnt_q;

endmodule

// File: tb/tb_lc3b_ctrl_pipe.sv
// Directed bench for lc3b_ctrl_pipe: in-order scoreboard on retire plus hand-derived counter values.
module tb_lc3b_ctrl_pipe;
    import lc3b_types::*;

    localparam int S  = 4;
    localparam int CW = LC3B_CW_BITS;
    localparam int PW = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic [CW-1:0]     in_cw = '0;
    logic [PW-1:0]     in_pc = '0;
    logic [S-1:0]      stall = '0;
    logic [S-1:0]      flush = '0;
    logic              in_ready, retire;
    logic [S-1:0]      stage_valid;
    logic [S*CW-1:0]   stage_cw;
    logic [S*PW-1:0]   stage_pc;
    logic [31:0]       retire_count, bubble_count;

    logic              w_in_ready, w_retire;
    logic [S-1:0]      w_stage_valid;
    logic [S*CW-1:0]   w_stage_cw;
    logic [S*PW-1:0]   w_stage_pc;
    logic [3:0]        w_retire_count, w_bubble_count;

    int errors = 0;
    int checks = 0;
    logic [PW-1:0] q[$];

    always #5 clk = ~clk;

    lc3b_ctrl_pipe #(.STAGES(S), .CW_WIDTH(CW), .PC_WIDTH(PW), .CNT_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_cw(in_cw), .in_pc(in_pc),
        .in_ready(in_ready), .stall(stall), .flush(flush), .stage_valid(stage_valid),
        .stage_cw(stage_cw), .stage_pc(stage_pc), .retire(retire),
        .retire_count(retire_count), .bubble_count(bubble_count)
    );

    lc3b_ctrl_pipe #(.STAGES(S), .CW_WIDTH(CW), .PC_WIDTH(PW), .CNT_WIDTH(4)) dut_w (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_cw(in_cw), .in_pc(in_pc),
        .in_ready(w_in_ready), .stall(stall), .flush(flush), .stage_valid(w_stage_valid),
        .stage_cw(w_stage_cw), .stage_pc(w_stage_pc), .retire(w_retire),
        .retire_count(w_retire_count), .bubble_count(w_bubble_count)
    );

    function automatic logic [CW-1:0] mkcw(input logic [PW-1:0] pc);
        return pc ^ 16'hA5C3;
    endfunction

    function automatic logic [PW-1:0] pc_at(input int i);
        return stage_pc[i*PW +: PW];
    endfunction

    function automatic logic [CW-1:0] cw_at(input int i);
        return stage_cw[i*CW +: CW];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic cyc(input logic v, input logic [PW-1:0] pc, input logic [S-1:0] st,
                       input logic [S-1:0] fl, input int drop_n, input int exp_rt);
        logic [PW-1:0] e;
        in_valid = v;
        in_pc    = pc;
        in_cw    = v ? mkcw(pc) : '0;
        stall    = st;
        flush    = fl;
        #1;
        chk("in_ready", in_ready, ~|st);
        if (exp_rt >= 0) chk("retire_exp", retire, exp_rt[0]);
        if (retire) begin
            chk("sb_nonempty", q.size() > 0, 1'b1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("retire_pc", pc_at(S-1), e);
                chk("retire_cw", cw_at(S-1), mkcw(e));
            end
        end
        repeat (drop_n) if (q.size() > 0) void'(q.pop_back());
        if (v && st == '0 && fl == '0) q.push_back(pc);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 16'h0, '0, '0, 0, -1);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_cw    = '0;
        in_pc    = '0;
        stall    = '0;
        flush    = '0;
        #1;
        chk("rst_valid", stage_valid, '0);
        chk("rst_cw", stage_cw, '0);
        chk("rst_pc", stage_pc, '0);
        chk("rst_rcnt", retire_count, '0);
        chk("rst_bcnt", bubble_count, '0);
        chk("rst_retire", retire, 1'b0);
        chk("rst_ready", in_ready, 1'b1);
        q.delete();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);

        // Streaming: first retire four cycles after acceptance, then every cycle.
        do_reset();
        for (int n = 1; n <= 14; n++)
            cyc(n <= 10, (n <= 10) ? 16'((n - 1) * 2) : 16'h0, '0, '0, 0, (n >= 5) ? 1 : 0);
        chk("a_rcnt", retire_count, 32'd10);
        chk("a_bcnt", bubble_count, 32'd4);
        chk("a_sb_empty", q.size(), 0);
        chk("a_valid", stage_valid, '0);

        // Stall of stage 2 for two cycles.
        do_reset();
        for (int n = 0; n < 4; n++) cyc(1'b1, 16'(16'h0100 + n * 2), '0, '0, 0, -1);
        cyc(1'b1, 16'h0108, 4'b0100, '0, 0, 1);
        chk("b_s0_frozen", pc_at(0), 16'h0106);
        chk("b_s2_frozen", pc_at(2), 16'h0102);
        chk("b_s3_bubble_v", stage_valid[3], 1'b0);
        chk("b_s3_bubble_cw", cw_at(3), '0);
        cyc(1'b1, 16'h0108, 4'b0100, '0, 0, 0);
        chk("b_s1_frozen", pc_at(1), 16'h0104);
        chk("b_s3_bubble2", stage_valid[3], 1'b0);
        for (int n = 4; n < 8; n++) cyc(1'b1, 16'(16'h0100 + n * 2), '0, '0, 0, -1);
        idle(4);
        chk("b_rcnt", retire_count, 32'd8);
        chk("b_bcnt", bubble_count, 32'd6);
        chk("b_sb_empty", q.size(), 0);

        // Flush of stages 0..1 together with a stall of stage 1.
        do_reset();
        for (int n = 0; n < 4; n++) cyc(1'b1, 16'(16'h0200 + n * 2), '0, '0, 0, -1);
        cyc(1'b1, 16'h0208, 4'b0010, 4'b0010, 2, 1);
        chk("c_valid", stage_valid, 4'b1000);
        chk("c_s3_pc", pc_at(3), 16'h0202);
        chk("c_young_cw", stage_cw[2*CW-1:0], '0);
        chk("c_young_pc", stage_pc[2*PW-1:0], '0);
        cyc(1'b1, 16'h020A, '0, '0, 0, 1);
        cyc(1'b1, 16'h020C, '0, '0, 0, 0);
        idle(4);
        chk("c_rcnt", retire_count, 32'd4);
        chk("c_bcnt", bubble_count, 32'd7);
        chk("c_sb_empty", q.size(), 0);

        // Flush of every stage: no retire, no counter movement.
        do_reset();
        for (int n = 0; n < 4; n++) cyc(1'b1, 16'(16'h0300 + n * 2), '0, '0, 0, -1);
        cyc(1'b1, 16'h0308, '0, 4'hF, 4, 0);
        chk("g_valid", stage_valid, '0);
        chk("g_rcnt", retire_count, 32'd0);
        chk("g_bcnt", bubble_count, 32'd4);
        chk("g_sb_empty", q.size(), 0);

        // Asynchronous reset with a full pipe, then gaps in the input stream.
        do_reset();
        for (int n = 0; n < 4; n++) cyc(1'b1, 16'(16'h0400 + n * 2), '0, '0, 0, -1);
        chk("d_full", stage_valid, 4'hF);
        do_reset();
        cyc(1'b1, 16'h0500, '0, '0, 0, 0);
        cyc(1'b0, 16'h0000, '0, '0, 0, 0);
        cyc(1'b1, 16'h0502, '0, '0, 0, 0);
        cyc(1'b0, 16'h0000, '0, '0, 0, 0);
        chk("e_pattern", stage_valid, 4'b1010);
        chk("e_gap_cw2", cw_at(2), '0);
        chk("e_gap_cw0", cw_at(0), '0);
        cyc(1'b0, 16'h0000, '0, '0, 0, 1);
        cyc(1'b0, 16'h0000, '0, '0, 0, 0);
        cyc(1'b0, 16'h0000, '0, '0, 0, 1);
        chk("e_rcnt", retire_count, 32'd2);
        chk("e_bcnt", bubble_count, 32'd5);
        chk("e_sb_empty", q.size(), 0);

        // Counter wrap on a 4-bit instance after 17 retires.
        do_reset();
        for (int n = 0; n < 17; n++) cyc(1'b1, 16'(16'h0600 + n * 2), '0, '0, 0, -1);
        idle(4);
        chk("f_rcnt32", retire_count, 32'd17);
        chk("f_rcnt4_wrap", w_retire_count, 4'd1);
        chk("f_bcnt4", w_bubble_count, 4'd4);
        chk("f_sb_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lc3b_ctrl_pipe.md
Name: lc3b_ctrl_pipe

Overview:
- Parametrised control-word pipeline for the LC-3b core: carries decoded control words and PCs from decode through the downstream stages (EX/MEM/WB).
- Provides per-stage valid bits, stall back-propagation, bubble insertion, and flush-younger.
- Provides retire and bubble performance counters.
- Generalises the fixed single control word to N stages of configurable width.

Parameters:
- STAGES, 4, number of pipeline stages; stage 0 is youngest, stage STAGES-1 is retire.
- CW_WIDTH, $bits(lc3b_control_word), control-word width in bits.
- PC_WIDTH, 16, width of the PC carried with each word.
- CNT_WIDTH, 32, width of the performance counters.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  decode presents a control word.
- in_cw  input  CW_WIDTH  incoming control word.
- in_pc  input  PC_WIDTH  PC of the incoming instruction.
- in_ready  output  1  stage 0 accepts this cycle.
- stall  input  STAGES  stall[i]: stage i must hold (e.g. memory not ready).
- flush  input  STAGES  flush[k]: kill stages 0..k at the next edge.
- stage_valid  output  STAGES  per-stage valid.
- stage_cw  output  STAGES*CW_WIDTH  flattened control words; stage i occupies [i*CW_WIDTH +: CW_WIDTH].
- stage_pc  output  STAGES*PC_WIDTH  flattened PCs, same packing.
- retire  output  1  the last stage retires a valid word this cycle.
- retire_count  output  CNT_WIDTH  retired instruction count.
- bubble_count  output  CNT_WIDTH  bubbles leaving the last stage.

Behaviour:
- Reset: asynchronous; stage_valid=0, all stage_cw=0, stage_pc=0, both counters=0.
  - Reset mid-operation discards all in-flight words immediately.
  - in_ready and retire follow combinationally from the cleared state.
- Hold chain (combinational):
  - hold[STAGES-1]=stall[STAGES-1].
  - hold[i]=stall[i] | hold[i+1].
  - Rigid pipeline: a stall freezes its stage and all younger stages, including invalid ones. There is no bubble collapse.
- in_ready = !hold[0] (independent of in_valid).
- Per-edge update for stage i, in priority order:
  1. Flush: if any flush[k] with k>=i is asserted, valid/cw/pc of stage i are cleared to 0. Flush beats stall.
  2. Hold: else if hold[i], stage i keeps its contents.
  3. Bubble: else if i>0 and hold[i-1], stage i loads a bubble (valid=0, cw=0, pc=0).
  4. Advance: else stage i loads stage i-1. Stage 0 loads in_cw/in_pc with valid=in_valid. When in_valid=0, stage 0 loads a bubble with cw=0.
- Invalid stages always hold cw=0, so mem_read, mem_write, load_regfile and load_cc are 0 in bubbles.
- retire = stage_valid[STAGES-1] & !hold[STAGES-1] & !flush[STAGES-1]. It is combinational, valid in the same cycle as the word.
- Counters:
  - retire_count += 1 on each retire.
  - bubble_count += 1 when the last stage is invalid, not held and not flushed.
  - Both wrap modulo 2^CNT_WIDTH with no saturation.
- Latency: a word accepted at edge t occupies stage i during cycle t+i (no stalls). Retire is asserted during cycle t+STAGES-1.
- Simultaneous events:
  - flush[k] together with stall[j], j>k: stages ≤k clear; stages k+1..j hold.
  - flush[k] together with in_valid & in_ready: the incoming word is dropped.
  - All flush bits set clears the whole pipe. Retire is 0 that cycle and neither counter increments.
- STAGES=1: stage 0 is also the retire stage; all rules above still apply.

Decomposition:
- Shared package lc3b_types gains:
  - typedef lc3b_pc (logic [15:0]).
  - Constant LC3B_CW_BITS = $bits(lc3b_control_word).
  - Constant LC3B_NOP_CW (all-zero control word).
  - Typedef lc3b_perf_cnt (logic [31:0]).
- One sub-module is natural: lc3b_ctrl_stage, a single stage register with flush/hold/load-bubble/load-next controls. It is instantiated STAGES times in a generate loop. Hold chain, counters and retire logic live in the top level.

Test Plan:
1. Reset then streaming: in_valid=1, PCs 0x0000,0x0002,… each cycle, STAGES=4 → PC 0x0000 at stage 3 on cycle 3, with retire=1 every cycle from cycle 3. After 10 inputs and 13 cycles, retire_count=10.
2. Stall: stall[2]=1 for 2 cycles during streaming → in_ready=0; stages 0–2 frozen. Stage 3 receives 2 bubbles (cw=0), so bubble_count+=2 and no PC is lost or duplicated afterwards.
3. Flush with stall: flush[1]=1 in the same cycle as stall[1]=1 → stages 0,1 become invalid with cw=0 next cycle; stages 2,3 advance normally. The incoming word that cycle is dropped.
4. Wrap: CNT_WIDTH=4, 17 retires → retire_count=1.
5. Async reset mid-stream: assert reset between edges with all stages valid → stage_valid=0 and counters=0 immediately, before the next clk edge. Streaming resumes cleanly after deassert.
6. Gaps: in_valid toggling 1,0,1,0 → stage_valid pattern propagates unchanged; each bubble has cw=0 (mem_write=0) and bubble_count increments once per gap.
